// File: rtl/encode_sched_pkg.sv
// rtl/encode_sched_pkg.sv - shared types and constants for the ByteEncode sequencer
package encode_sched_pkg;

    localparam int COEFF_W        = 24;
    localparam int WORDS_PER_POLY = 128;

    typedef enum logic [1:0] {
        MODE_PK  = 2'd0,
        MODE_CT  = 2'd1,
        MODE_MSG = 2'd2,
        MODE_ILL = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [3:0] L_PK   = 4'd12;
    localparam logic [3:0] L_MSG  = 4'd1;
    localparam logic [3:0] DU_LO  = 4'd10;
    localparam logic [3:0] DU_HI  = 4'd11;
    localparam logic [3:0] DV_LO  = 4'd4;
    localparam logic [3:0] DV_HI  = 4'd5;

    // 256 coefficients at l bits = 32*l bytes = 4*l 64-bit words
    function automatic logic [7:0] obytes_words(input logic [3:0] l);
        return {2'b00, l, 2'b00};
    endfunction

endpackage

// File: rtl/encode_sched_if.sv
// rtl/encode_sched_if.sv - handshake bundle between sequencer and ByteEncode core
interface encode_sched_if;
    logic [3:0]  l;
    logic [23:0] coeffs;
    logic        coeffs_valid;
    logic        coeffs_ready;
    logic [63:0] obytes;
    logic        obytes_valid;
    logic        done;

    modport master (
        output l, coeffs, coeffs_valid,
        input  coeffs_ready, obytes, obytes_valid, done
    );

    modport slave (
        input  l, coeffs, coeffs_valid,
        output coeffs_ready, obytes, obytes_valid, done
    );
endinterface

// File: rtl/encode_sched_fifo.sv
// rtl/encode_sched_fifo.sv - 2-deep coefficient FIFO that also accounts for the RAM read in flight
module encode_sched_fifo
    import encode_sched_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_rd,
    input  logic [COEFF_W-1:0] i_rdata,
    input  logic               i_pop,
    output logic [COEFF_W-1:0] o_head,
    output logic               o_valid,
    output logic               o_credit,
    output logic               o_idle
);

    logic [COEFF_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               inflight;
    logic               push;
    logic               pop;
    logic [2:0]         occ_after;

    assign push = inflight;
    assign pop  = i_pop && (count != 2'd0);

    // Credit counts the slot freed by a same-cycle pop so a held-high ready sustains one read per cycle
    assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign o_credit  = (occ_after < 3'd2);
    assign o_idle    = (count == 2'd0) && !inflight;
    assign o_valid   = (count != 2'd0);
    assign o_head    = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= i_rd;
            if (push) begin
                mem[wr_ptr] <= i_rdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/encode_sched.sv
// rtl/encode_sched.sv - sequences ByteEncode over every polynomial of a PK, CT or message object
module encode_sched
    import encode_sched_pkg::*;
#(
    parameter int CMEM_AW = 9,
    parameter int OBUF_AW = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic [2:0]         i_k,
    input  logic [3:0]         i_du,
    input  logic [3:0]         i_dv,
    output logic               o_cmem_rd,
    output logic [CMEM_AW-1:0] o_cmem_addr,
    input  logic [23:0]        i_cmem_rdata,
    encode_sched_if.master     enc,
    output logic               o_obuf_we,
    output logic [OBUF_AW-1:0] o_obuf_addr,
    output logic [63:0]        o_obuf_wdata,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    state_e             state, nstate;
    mode_e              mode_q;
    logic [2:0]         k_q;
    logic [3:0]         du_q, dv_q;
    logic [2:0]         poly_idx;
    logic [7:0]         word_idx;
    logic [7:0]         poly_words;
    logic [OBUF_AW-1:0] out_addr;
    logic [3:0]         l_q;
    logic               err_q;

    logic               legal, k_ok, du_ok, dv_ok;
    logic [2:0]         npolys;
    logic [3:0]         first_l;
    logic               last_poly, in_core, rd_en, pop, credit, fifo_idle;
    logic               feed_complete, obv_ok, count_bad;
    logic [7:0]         words_at_done;

    assign k_ok  = (k_q >= 3'd2) && (k_q <= 3'd4);
    assign du_ok = (du_q == DU_LO) || (du_q == DU_HI);
    assign dv_ok = (dv_q == DV_LO) || (dv_q == DV_HI);

    always_comb begin
        legal   = 1'b0;
        npolys  = 3'd0;
        first_l = 4'd0;
        case (mode_q)
            MODE_PK: begin
                legal   = k_ok;
                npolys  = k_q;
                first_l = L_PK;
            end
            MODE_CT: begin
                legal   = k_ok && du_ok && dv_ok;
                npolys  = k_q + 3'd1;
                first_l = du_q;
            end
            MODE_MSG: begin
                legal   = 1'b1;
                npolys  = 3'd1;
                first_l = L_MSG;
            end
            default: ;
        endcase
    end

    assign last_poly     = ((poly_idx + 3'd1) == npolys);
    assign in_core       = (state == S_FEED) || (state == S_DRAIN);
    assign pop           = enc.coeffs_valid && enc.coeffs_ready;
    assign rd_en         = (state == S_FEED) && (word_idx < 8'(WORDS_PER_POLY)) && credit;
    assign feed_complete = (word_idx == 8'(WORDS_PER_POLY)) && fifo_idle;
    assign obv_ok        = enc.obytes_valid && in_core;
    assign words_at_done = poly_words + {7'd0, obv_ok};
    assign count_bad     = in_core && enc.done && (words_at_done != obytes_words(l_q));

    encode_sched_fifo u_fifo (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_rd     (rd_en),
        .i_rdata  (i_cmem_rdata),
        .i_pop    (pop),
        .o_head   (enc.coeffs),
        .o_valid  (enc.coeffs_valid),
        .o_credit (credit),
        .o_idle   (fifo_idle)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (i_start) nstate = S_SETUP;
            S_SETUP: nstate = legal ? S_FEED : S_DONE;
            S_FEED: begin
                if (feed_complete) begin
                    if (enc.done) nstate = last_poly ? S_DONE : S_NEXT;
                    else          nstate = S_DRAIN;
                end
            end
            S_DRAIN: if (enc.done) nstate = last_poly ? S_DONE : S_NEXT;
            S_NEXT:  nstate = S_FEED;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mode_q       <= MODE_PK;
            k_q          <= 3'd0;
            du_q         <= 4'd0;
            dv_q         <= 4'd0;
            poly_idx     <= 3'd0;
            word_idx     <= 8'd0;
            poly_words   <= 8'd0;
            out_addr     <= '0;
            l_q          <= 4'd0;
            err_q        <= 1'b0;
            o_obuf_we    <= 1'b0;
            o_obuf_addr  <= '0;
            o_obuf_wdata <= 64'd0;
        end else begin
            if ((state == S_IDLE) && i_start) begin
                mode_q <= mode_e'(i_mode);
                k_q    <= i_k;
                du_q   <= i_du;
                dv_q   <= i_dv;
                err_q  <= 1'b0;
            end
            if (state == S_SETUP) begin
                poly_idx   <= 3'd0;
                word_idx   <= 8'd0;
                poly_words <= 8'd0;
                out_addr   <= '0;
                if (legal) l_q <= first_l;
                else       err_q <= 1'b1;
            end
            if (state == S_NEXT) begin
                poly_idx   <= poly_idx + 3'd1;
                word_idx   <= 8'd0;
                poly_words <= 8'd0;
                // The final CT polynomial switches from du to dv
                if ((mode_q == MODE_CT) && ((poly_idx + 3'd1) == k_q)) l_q <= dv_q;
            end
            if (rd_en) word_idx <= word_idx + 8'd1;
            if (obv_ok) begin
                poly_words   <= poly_words + 8'd1;
                o_obuf_wdata <= enc.obytes;
                o_obuf_addr  <= out_addr;
                out_addr     <= out_addr + 1'b1;
            end
            o_obuf_we <= obv_ok;
            if ((enc.obytes_valid && !in_core) || count_bad) err_q <= 1'b1;
        end
    end

    assign o_cmem_rd   = rd_en;
    assign o_cmem_addr = CMEM_AW'({poly_idx[1:0], word_idx[6:0]});
    assign enc.l       = l_q;
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_err       = err_q;

endmodule

// File: tb/tb_encode_sched.sv
// tb/tb_encode_sched.sv - scoreboard bench for encode_sched with a behavioural RAM and core
module tb_encode_sched;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [2:0]  i_k = 3'd0;
    logic [3:0]  i_du = 4'd0;
    logic [3:0]  i_dv = 4'd0;
    logic        o_cmem_rd;
    logic [8:0]  o_cmem_addr;
    logic [23:0] i_cmem_rdata = 24'd0;
    logic        o_obuf_we;
    logic [7:0]  o_obuf_addr;
    logic [63:0] o_obuf_wdata;
    logic        o_busy, o_done, o_err;

    encode_sched_if enc();

    encode_sched #(.CMEM_AW(9), .OBUF_AW(8)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_k          (i_k),
        .i_du         (i_du),
        .i_dv         (i_dv),
        .o_cmem_rd    (o_cmem_rd),
        .o_cmem_addr  (o_cmem_addr),
        .i_cmem_rdata (i_cmem_rdata),
        .enc          (enc),
        .o_obuf_we    (o_obuf_we),
        .o_obuf_addr  (o_obuf_addr),
        .o_obuf_wdata (o_obuf_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct { logic [23:0] d; logic [3:0] l; } cexp_t;
    typedef struct { logic [7:0] a; logic [63:0] d; } wexp_t;

    cexp_t      coeff_q[$];
    logic [8:0] addr_q[$];
    wexp_t      wr_q[$];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int rd_cnt = 0, acc_cnt = 0, wr_cnt = 0, done_cnt = 0, max_out = 0;
    int edone_cyc = 0, odone_cyc = 0, seq = 0;
    int short_poly = -1;
    bit hs = 1'b0, rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event with no expectation queued", name);
    endtask

    function automatic logic [23:0] cm_data(input logic [8:0] a);
        return {a, 3'b011, a ^ 9'h155, 3'b000};
    endfunction

    initial forever @(posedge i_clk) cyc++;

    // coefficient RAM: one-cycle read latency
    initial begin : ram
        logic       r;
        logic [8:0] a;
        forever begin
            @(negedge i_clk);
            r = o_cmem_rd;
            a = o_cmem_addr;
            @(posedge i_clk);
            #1;
            i_cmem_rdata = r ? cm_data(a) : 24'd0;
        end
    end

    // monitor: pops and compares every DUT-presented transfer
    initial begin : mon
        cexp_t ce;
        wexp_t we;
        forever begin
            @(negedge i_clk);
            hs = 1'b0;
            if (i_rstn) begin
                if (o_cmem_rd) begin
                    rd_cnt++;
                    if (addr_q.size() == 0) fail_now("cmem_rd");
                    else check("cmem_addr", 64'(o_cmem_addr), 64'(addr_q.pop_front()));
                end
                if (enc.coeffs_valid && enc.coeffs_ready) begin
                    hs = 1'b1;
                    acc_cnt++;
                    if (coeff_q.size() == 0) fail_now("enc_coeffs");
                    else begin
                        ce = coeff_q.pop_front();
                        check("enc_coeffs", 64'(enc.coeffs), 64'(ce.d));
                        check("enc_l", 64'(enc.l), 64'(ce.l));
                    end
                end
                if (rd_cnt - acc_cnt > max_out) max_out = rd_cnt - acc_cnt;
                if (o_obuf_we) begin
                    wr_cnt++;
                    if (wr_q.size() == 0) fail_now("obuf_we");
                    else begin
                        we = wr_q.pop_front();
                        check("obuf_addr", 64'(o_obuf_addr), 64'(we.a));
                        check("obuf_wdata", o_obuf_wdata, we.d);
                    end
                end
                if (o_done) begin
                    done_cnt++;
                    odone_cyc = cyc;
                end
            end
        end
    end

    // behavioural ByteEncode core: takes 128 words, emits 4*l words, then pulses done
    initial begin : core
        int         rx, left, pcnt;
        bit         tx;
        logic [7:0] waddr;
        logic [63:0] ob;
        rx = 0; left = 0; pcnt = 0; tx = 1'b0; waddr = 8'd0;
        enc.coeffs_ready = 1'b0;
        enc.obytes_valid = 1'b0;
        enc.obytes       = 64'd0;
        enc.done         = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            enc.obytes_valid = 1'b0;
            enc.done         = 1'b0;
            if (!i_rstn || !o_busy) begin
                rx = 0; tx = 1'b0; pcnt = 0; waddr = 8'd0;
            end else begin
                if (hs) rx++;
                if (!tx && rx == 128) begin
                    tx   = 1'b1;
                    left = (pcnt == short_poly) ? 47 : 4 * int'(enc.l);
                end
                if (tx) begin
                    if (left > 0) begin
                        ob = {32'hC0DE_0000 | 32'(seq), 32'(seq * 7 + 1)};
                        enc.obytes_valid = 1'b1;
                        enc.obytes       = ob;
                        wr_q.push_back('{waddr, ob});
                        waddr++;
                        seq++;
                        left--;
                    end else begin
                        enc.done  = 1'b1;
                        edone_cyc = cyc;
                        tx = 1'b0;
                        rx = 0;
                        pcnt++;
                    end
                end
            end
            enc.coeffs_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_run(input logic [1:0] mode, input logic [2:0] k,
                             input logic [3:0] du, input logic [3:0] dv);
        bit         lg;
        int         np, slot;
        logic [2:0] s;
        logic [3:0] lv;
        logic [8:0] a;
        lg = (mode == 2'd2) ||
             ((mode == 2'd0 || mode == 2'd1) && k >= 3'd2 && k <= 3'd4 &&
              (mode == 2'd0 || ((du == 4'd10 || du == 4'd11) && (dv == 4'd4 || dv == 4'd5))));
        np = !lg ? 0 : (mode == 2'd0) ? int'(k) : (mode == 2'd1) ? int'(k) + 1 : 1;
        for (int p = 0; p < np; p++) begin
            slot = (mode == 2'd2) ? 0 : p;
            s    = 3'(slot);
            lv   = (mode == 2'd0) ? 4'd12 : (mode == 2'd2) ? 4'd1 : ((p < int'(k)) ? du : dv);
            for (int w = 0; w < 128; w++) begin
                a = {s[1:0], 7'(w)};
                addr_q.push_back(a);
                coeff_q.push_back('{cm_data(a), lv});
            end
        end
        rd_cnt = 0; acc_cnt = 0; wr_cnt = 0; done_cnt = 0; max_out = 0;
        edone_cyc = -100; odone_cyc = -200;
        @(posedge i_clk);
        #1;
        i_mode = mode; i_k = k; i_du = du; i_dv = dv;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic finish_run(input string tn, input bit exp_err, input int exp_rd,
                              input int exp_wr, input int restart_at, input bit chk_lat);
        int t;
        t = 0;
        do begin
            @(negedge i_clk);
            t++;
            i_start = (t == restart_at);
            if (t == restart_at) i_mode = 2'd3;
        end while (!o_done && t < 20000);
        i_start = 1'b0;
        if (t >= 20000) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.timeout: got no o_done expected o_done within 20000 cycles", tn);
        end
        repeat (4) @(negedge i_clk);
        check({tn, ".done_pulses"}, 64'(done_cnt), 64'd1);
        check({tn, ".busy"}, 64'(o_busy), 64'd0);
        check({tn, ".err"}, 64'(o_err), 64'(exp_err));
        check({tn, ".reads"}, 64'(rd_cnt), 64'(exp_rd));
        check({tn, ".writes"}, 64'(wr_cnt), 64'(exp_wr));
        check({tn, ".coeff_left"}, 64'(coeff_q.size() + addr_q.size()), 64'd0);
        check({tn, ".wr_left"}, 64'(wr_q.size()), 64'd0);
        check({tn, ".occupancy_le2"}, 64'(max_out <= 2), 64'd1);
        if (chk_lat) check({tn, ".done_latency"}, 64'(odone_cyc - edone_cyc), 64'd1);
    endtask

    initial begin : main
        int t;
        repeat (3) @(negedge i_clk);
        check("reset.ctrl", 64'({o_cmem_rd, o_cmem_addr, enc.l, enc.coeffs_valid,
                                 o_obuf_we, o_obuf_addr, o_busy, o_done, o_err}), 64'd0);
        check("reset.coeffs", 64'(enc.coeffs), 64'd0);
        check("reset.wdata", o_obuf_wdata, 64'd0);
        i_rstn = 1'b1;

        start_run(2'd0, 3'd3, 4'd0, 4'd0);
        finish_run("pk3", 1'b0, 384, 144, -1, 1'b1);

        start_run(2'd1, 3'd4, 4'd11, 4'd5);
        finish_run("ct4", 1'b0, 640, 196, 300, 1'b1);

        start_run(2'd3, 3'd2, 4'd10, 4'd4);
        finish_run("ill_mode", 1'b1, 0, 0, -1, 1'b0);

        start_run(2'd1, 3'd2, 4'd9, 4'd4);
        finish_run("ill_du", 1'b1, 0, 0, -1, 1'b0);

        start_run(2'd2, 3'd0, 4'd0, 4'd0);
        finish_run("msg", 1'b0, 128, 4, -1, 1'b1);

        rand_ready = 1'b1;
        start_run(2'd0, 3'd2, 4'd0, 4'd0);
        finish_run("pk2_rand", 1'b0, 256, 96, -1, 1'b1);
        rand_ready = 1'b0;

        short_poly = 0;
        start_run(2'd0, 3'd2, 4'd0, 4'd0);
        finish_run("short", 1'b1, 256, 95, -1, 1'b1);
        short_poly = -1;

        start_run(2'd0, 3'd2, 4'd0, 4'd0);
        t = 0;
        while (acc_cnt < 160 && t < 2000) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 2000) begin
            n_cmp++; n_bad++;
            $display("FAIL abort.reach_poly1: got %0d words expected 160 within 2000 cycles", acc_cnt);
        end
        @(negedge i_clk);
        #2 i_rstn = 1'b0;
        #1;
        check("abort.ctrl", 64'({o_cmem_rd, o_cmem_addr, enc.l, enc.coeffs_valid,
                                 o_obuf_we, o_obuf_addr, o_busy, o_done, o_err}), 64'd0);
        check("abort.coeffs", 64'(enc.coeffs), 64'd0);
        check("abort.wdata", o_obuf_wdata, 64'd0);
        repeat (2) @(negedge i_clk);
        addr_q.delete();
        coeff_q.delete();
        wr_q.delete();
        i_rstn = 1'b1;

        start_run(2'd2, 3'd0, 4'd0, 4'd0);
        finish_run("post_abort", 1'b0, 128, 4, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
